// File: rtl/axi4_req_splitter.sv
// Splits AXI4 AW/W and AR bursts into bounded, 4KB-safe memory requests.
// Define AXI4_REQ_SPLITTER_READ_EN to compile in the AR path.
module axi4_req_splitter #(
   parameter int unsigned ID_WIDTH        = 4,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 256,
   parameter int unsigned CHUNK_MAX_BEATS = 4,
   parameter logic [15:0] BDF             = 16'h0100
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  awvalid_in,
   output logic                                  awready_out,
   input  logic [ID_WIDTH-1:0]                   awid_in,
   input  logic [ADDR_WIDTH-1:0]                 awaddr_in,
   input  logic [7:0]                            awlen_in,
   input  logic                                  wvalid_in,
   output logic                                  wready_out,
   input  logic [DATA_WIDTH-1:0]                 wdata_in,
   input  logic                                  wlast_in,
   output logic                                  bvalid_out,
   input  logic                                  bready_in,
   output logic [ID_WIDTH-1:0]                   bid_out,
   input  logic                                  arvalid_in,
   output logic                                  arready_out,
   input  logic [ID_WIDTH-1:0]                   arid_in,
   input  logic [ADDR_WIDTH-1:0]                 araddr_in,
   input  logic [7:0]                            arlen_in,
   output logic [ADDR_WIDTH-1:0]                 out_addr,
   output logic [9:0]                            out_length,
   output logic [15:0]                           out_bdf,
   output logic                                  out_is_memwrite,
   output logic [ID_WIDTH-1:0]                   out_tag,
   output logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] out_wdata,
   output logic                                  out_valid,
   input  logic                                  out_ready
);

   localparam int unsigned BYTES       = DATA_WIDTH / 8;
   localparam int unsigned BSH         = $clog2(BYTES);
   localparam int unsigned LCW         = $clog2(CHUNK_MAX_BEATS + 1);
   localparam int unsigned DW_PER_BEAT = DATA_WIDTH / 32;

   typedef enum logic [2:0] {
      IDLE,
      WR_COLLECT,
      WR_ISSUE,
      WR_RESP
`ifdef AXI4_REQ_SPLITTER_READ_EN
      , RD_ISSUE
`endif
   } state_t;

   state_t state, state_d;

   logic                                  aw_rdy_q, aw_rdy_d;
   logic                                  ar_rdy_q, ar_rdy_d;
   logic                                  prio_rd_q;
   logic [ID_WIDTH-1:0]                   id_q;
   logic [ADDR_WIDTH-1:0]                 addr_q;
   logic [8:0]                            rem_q;
   logic [LCW-1:0]                        lane_cnt_q;
   logic                                  wlast_seen_q;
   logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] wbuf_q;

   logic        ar_req, wr_pick, rd_pick;
   logic        aw_hs, ar_hs, w_hs, out_hs, collect_done;
   logic [12:0] bound_beats, rem_ext, chunk_beats, issue_beats;
   logic [8:0]  rem_after;

`ifdef AXI4_REQ_SPLITTER_READ_EN
   assign ar_req      = arvalid_in;
   assign arready_out = ar_rdy_q;
   assign out_valid   = (state == WR_ISSUE) || (state == RD_ISSUE);
`else
   assign ar_req      = 1'b0;
   assign arready_out = 1'b0;
   assign out_valid   = (state == WR_ISSUE);
`endif

   // Ready is registered one cycle after the grant, so it stays 0 during reset.
   assign wr_pick = awvalid_in && (!ar_req || !prio_rd_q);
   assign rd_pick = ar_req && !wr_pick;

   assign aw_hs  = aw_rdy_q && awvalid_in;
   assign ar_hs  = ar_rdy_q && arvalid_in;
   assign w_hs   = (state == WR_COLLECT) && wvalid_in;
   assign out_hs = out_valid && out_ready;

   // Beats remaining before the next 4KB page; addresses are beat-aligned.
   assign bound_beats = (13'h1000 - {1'b0, addr_q[11:0]}) >> BSH;
   assign rem_ext     = 13'(rem_q);

   always_comb begin
      chunk_beats = 13'(CHUNK_MAX_BEATS);
      if (rem_ext < chunk_beats)     chunk_beats = rem_ext;
      if (bound_beats < chunk_beats) chunk_beats = bound_beats;
   end

   assign issue_beats  = (state == WR_ISSUE) ? 13'(lane_cnt_q) : chunk_beats;
   assign rem_after    = rem_q - 9'(issue_beats);
   assign collect_done = w_hs && ((13'(lane_cnt_q) + 13'd1 == chunk_beats) || wlast_in);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         aw_rdy_q <= 1'b0;
         ar_rdy_q <= 1'b0;
      end else begin
         state    <= state_d;
         aw_rdy_q <= aw_rdy_d;
         ar_rdy_q <= ar_rdy_d;
      end
   end

   always_comb begin
      state_d  = state;
      aw_rdy_d = 1'b0;
      ar_rdy_d = 1'b0;
      case (state)
         IDLE: begin
            if (aw_hs) begin
               state_d = WR_COLLECT;
`ifdef AXI4_REQ_SPLITTER_READ_EN
            end else if (ar_hs) begin
               state_d = RD_ISSUE;
`endif
            end else if (!aw_rdy_q && !ar_rdy_q) begin
               if (wr_pick)      aw_rdy_d = 1'b1;
               else if (rd_pick) ar_rdy_d = 1'b1;
            end
         end
         WR_COLLECT: if (collect_done) state_d = WR_ISSUE;
         WR_ISSUE: begin
            if (out_hs) begin
               if (rem_after == 9'd0 || wlast_seen_q) state_d = WR_RESP;
               else                                   state_d = WR_COLLECT;
            end
         end
         WR_RESP: if (bready_in) state_d = IDLE;
`ifdef AXI4_REQ_SPLITTER_READ_EN
         RD_ISSUE: if (out_hs && rem_after == 9'd0) state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_rd_q    <= 1'b0;
         id_q         <= '0;
         addr_q       <= '0;
         rem_q        <= '0;
         lane_cnt_q   <= '0;
         wlast_seen_q <= 1'b0;
         wbuf_q       <= '0;
      end else begin
         if (aw_rdy_d)      prio_rd_q <= 1'b1;
         else if (ar_rdy_d) prio_rd_q <= 1'b0;

         if (aw_hs) begin
            id_q         <= awid_in;
            addr_q       <= awaddr_in;
            rem_q        <= 9'(awlen_in) + 9'd1;
            lane_cnt_q   <= '0;
            wlast_seen_q <= 1'b0;
            wbuf_q       <= '0;
         end else if (ar_hs) begin
            id_q         <= arid_in;
            addr_q       <= araddr_in;
            rem_q        <= 9'(arlen_in) + 9'd1;
            lane_cnt_q   <= '0;
            wlast_seen_q <= 1'b0;
            wbuf_q       <= '0;
         end else if (w_hs) begin
            for (int unsigned k = 0; k < CHUNK_MAX_BEATS; k++) begin
               if (lane_cnt_q == LCW'(k)) wbuf_q[k*DATA_WIDTH +: DATA_WIDTH] <= wdata_in;
            end
            lane_cnt_q <= lane_cnt_q + LCW'(1);
            if (wlast_in) wlast_seen_q <= 1'b1;
         end else if (out_hs) begin
            addr_q     <= addr_q + (ADDR_WIDTH'(issue_beats) << BSH);
            rem_q      <= rem_after;
            lane_cnt_q <= '0;
            wbuf_q     <= '0;
         end
      end
   end

   assign awready_out     = aw_rdy_q;
   assign wready_out      = (state == WR_COLLECT);
   assign bvalid_out      = (state == WR_RESP);
   assign bid_out         = id_q;
   assign out_addr        = addr_q;
   assign out_length      = out_valid ? 10'(issue_beats * 13'(DW_PER_BEAT)) : '0;
   assign out_bdf         = BDF;
   assign out_is_memwrite = (state == WR_ISSUE);
   assign out_tag         = id_q;
   assign out_wdata       = (state == WR_ISSUE) ? wbuf_q : '0;

endmodule

// File: tb/tb_axi4_req_splitter.sv
// Directed self-checking bench for axi4_req_splitter.
module tb_axi4_req_splitter;

   localparam int unsigned IDW = 4;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 256;
   localparam int unsigned CMB = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           awvalid_in = 1'b0, awready_out;
   logic [IDW-1:0] awid_in = '0;
   logic [AW-1:0]  awaddr_in = '0;
   logic [7:0]     awlen_in = '0;
   logic           wvalid_in = 1'b0, wready_out;
   logic [DW-1:0]  wdata_in = '0;
   logic           wlast_in = 1'b0;
   logic           bvalid_out, bready_in = 1'b0;
   logic [IDW-1:0] bid_out;
   logic           arvalid_in = 1'b0, arready_out;
   logic [IDW-1:0] arid_in = '0;
   logic [AW-1:0]  araddr_in = '0;
   logic [7:0]     arlen_in = '0;
   logic [AW-1:0]  out_addr;
   logic [9:0]     out_length;
   logic [15:0]    out_bdf;
   logic           out_is_memwrite;
   logic [IDW-1:0] out_tag;
   logic [DW*CMB-1:0] out_wdata;
   logic           out_valid, out_ready = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   axi4_req_splitter #(
      .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .CHUNK_MAX_BEATS(CMB), .BDF(16'h0100)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .awvalid_in(awvalid_in), .awready_out(awready_out), .awid_in(awid_in),
      .awaddr_in(awaddr_in), .awlen_in(awlen_in),
      .wvalid_in(wvalid_in), .wready_out(wready_out), .wdata_in(wdata_in), .wlast_in(wlast_in),
      .bvalid_out(bvalid_out), .bready_in(bready_in), .bid_out(bid_out),
      .arvalid_in(arvalid_in), .arready_out(arready_out), .arid_in(arid_in),
      .araddr_in(araddr_in), .arlen_in(arlen_in),
      .out_addr(out_addr), .out_length(out_length), .out_bdf(out_bdf),
      .out_is_memwrite(out_is_memwrite), .out_tag(out_tag), .out_wdata(out_wdata),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] beat(input int unsigned k);
      return {8{32'hD0D0_0000 + 32'(k)}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_aw(input logic [IDW-1:0] id, input logic [AW-1:0] a,
                          input logic [7:0] len, output bit ok);
      ok = 1'b0;
      awid_in = id; awaddr_in = a; awlen_in = len; awvalid_in = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (awready_out) ok = 1'b1;
         else tick();
      end
      if (ok) tick();
      awvalid_in = 1'b0;
   endtask

   task automatic send_ar(input logic [IDW-1:0] id, input logic [AW-1:0] a,
                          input logic [7:0] len, output bit ok);
      ok = 1'b0;
      arid_in = id; araddr_in = a; arlen_in = len; arvalid_in = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (arready_out) ok = 1'b1;
         else tick();
      end
      if (ok) tick();
      arvalid_in = 1'b0;
   endtask

   task automatic send_w(input logic [DW-1:0] d, input logic last, output bit ok);
      ok = 1'b0;
      wdata_in = d; wlast_in = last; wvalid_in = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (wready_out) ok = 1'b1;
         else tick();
      end
      if (ok) tick();
      wvalid_in = 1'b0; wlast_in = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (out_valid) ok = 1'b1;
         else tick();
      end
   endtask

   task automatic wait_b(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (bvalid_out) ok = 1'b1;
         else tick();
      end
   endtask

   task automatic accept_out();
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic accept_b();
      bready_in = 1'b1; tick(); bready_in = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      logic [79:0] got;
      rst_n = 1'b0;
      awvalid_in = 1'b1; arvalid_in = 1'b1; wvalid_in = 1'b1;
      out_ready = 1'b1; bready_in = 1'b1;
      tick(); tick(); tick();
      got = 80'({awready_out, arready_out, wready_out, bvalid_out, bid_out, out_addr,
                 out_length, out_is_memwrite, out_tag, out_valid});
      n_cmp++;
      if (got !== '0) begin
         $display("FAIL reset_outputs: got %h expected 0", got); n_err++;
      end
      n_cmp++;
      if (out_wdata !== '0) begin
         $display("FAIL reset_wdata: got nonzero expected 0"); n_err++;
      end
      n_cmp++;
      if (out_bdf !== 16'h0100) begin
         $display("FAIL reset_bdf: got %h expected 0100", out_bdf); n_err++;
      end
      awvalid_in = 1'b0; arvalid_in = 1'b0; wvalid_in = 1'b0;
      out_ready = 1'b0; bready_in = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_write();
      bit ok, all_ok;
      logic [DW*CMB-1:0] exp;
      send_aw(4'd5, 32'h1000, 8'd3, ok);
      all_ok = ok;
      for (int j = 0; j < 4; j++) begin
         send_w(beat(j), j == 3, ok);
         all_ok &= ok;
      end
      n_cmp++;
      if (!all_ok) begin $display("FAIL single_handshakes: got timeout expected handshakes"); n_err++; end
      wait_out(ok);
      n_cmp++;
      if (!ok) begin $display("FAIL single_out_valid: got 0 expected 1"); n_err++; end
      n_cmp++;
      if ({out_addr, out_length, out_is_memwrite, out_tag, out_bdf} !== {32'h1000, 10'd32, 1'b1, 4'd5, 16'h0100}) begin
         $display("FAIL single_hdr: got %h/%0d/%b/%h/%h expected 1000/32/1/5/0100",
                  out_addr, out_length, out_is_memwrite, out_tag, out_bdf);
         n_err++;
      end
      exp = {beat(3), beat(2), beat(1), beat(0)};
      n_cmp++;
      if (out_wdata !== exp) begin $display("FAIL single_wdata: got %h expected %h", out_wdata, exp); n_err++; end
      accept_out();
      wait_b(ok);
      n_cmp++;
      if (!ok || bid_out !== 4'd5 || out_valid !== 1'b0) begin
         $display("FAIL single_bresp: got bvalid=%b bid=%h out_valid=%b expected 1/5/0", bvalid_out, bid_out, out_valid);
         n_err++;
      end
      accept_b();
      n_cmp++;
      if (bvalid_out !== 1'b0) begin $display("FAIL single_bdone: got %b expected 0", bvalid_out); n_err++; end
   endtask

   task automatic test_multi_chunk();
      bit ok, all_ok;
      int unsigned nb;
      logic [DW*CMB-1:0] exp;
      send_aw(4'd3, 32'h2000, 8'd9, ok);
      n_cmp++;
      if (!ok) begin $display("FAIL multi_aw: got timeout expected handshake"); n_err++; end
      for (int unsigned c = 0; c < 3; c++) begin
         nb = (c < 2) ? 4 : 2;
         all_ok = 1'b1;
         exp = '0;
         for (int unsigned j = 0; j < nb; j++) begin
            send_w(beat(c*4 + j), (c*4 + j) == 9, ok);
            all_ok &= ok;
            exp[j*DW +: DW] = beat(c*4 + j);
         end
         wait_out(ok);
         all_ok &= ok;
         n_cmp++;
         if (!all_ok) begin $display("FAIL multi_chunk%0d_timeout: got timeout expected request", c); n_err++; end
         n_cmp++;
         if ({out_addr, out_length, out_is_memwrite, out_tag} !== {32'h2000 + 32'(c) * 32'h80, 10'(nb * 8), 1'b1, 4'd3}) begin
            $display("FAIL multi_chunk%0d_hdr: got %h/%0d/%b/%h expected %h/%0d/1/3",
                     c, out_addr, out_length, out_is_memwrite, out_tag, 32'h2000 + 32'(c) * 32'h80, nb * 8);
            n_err++;
         end
         n_cmp++;
         if (out_wdata !== exp) begin $display("FAIL multi_chunk%0d_wdata: got %h expected %h", c, out_wdata, exp); n_err++; end
         accept_out();
      end
      wait_b(ok);
      n_cmp++;
      if (!ok || bid_out !== 4'd3) begin $display("FAIL multi_bresp: got bvalid=%b bid=%h expected 1/3", bvalid_out, bid_out); n_err++; end
      accept_b();
   endtask

`ifdef AXI4_REQ_SPLITTER_READ_EN
   task automatic test_read_split();
      bit ok;
      send_ar(4'd6, 32'h0FC0, 8'd3, ok);
      n_cmp++;
      if (!ok) begin $display("FAIL read_ar: got timeout expected handshake"); n_err++; end
      for (int unsigned c = 0; c < 2; c++) begin
         wait_out(ok);
         n_cmp++;
         if (!ok || {out_addr, out_length, out_is_memwrite, out_tag} !== {32'h0FC0 + 32'(c) * 32'h40, 10'd16, 1'b0, 4'd6}) begin
            $display("FAIL read_chunk%0d_hdr: got %h/%0d/%b/%h expected %h/16/0/6",
                     c, out_addr, out_length, out_is_memwrite, out_tag, 32'h0FC0 + 32'(c) * 32'h40);
            n_err++;
         end
         n_cmp++;
         if (out_wdata !== '0) begin $display("FAIL read_chunk%0d_wdata: got nonzero expected 0", c); n_err++; end
         accept_out();
      end
      tick(); tick();
      n_cmp++;
      if ({out_valid, bvalid_out} !== 2'b00) begin
         $display("FAIL read_done: got out_valid=%b bvalid=%b expected 0/0", out_valid, bvalid_out); n_err++;
      end
   endtask
`endif

   task automatic test_arbitration();
      bit ok;
      logic [1:0] grant;
      do_reset();
      awid_in = 4'd1; awaddr_in = 32'h3000; awlen_in = 8'd0; awvalid_in = 1'b1;
      arid_in = 4'd2; araddr_in = 32'h4000; arlen_in = 8'd0; arvalid_in = 1'b1;
      grant = 2'b00;
      for (int i = 0; i < 20 && grant == 2'b00; i++) begin
         if (awready_out || arready_out) grant = {awready_out, arready_out};
         else tick();
      end
      n_cmp++;
      if (grant !== 2'b10) begin $display("FAIL arb_first_grant: got aw/ar=%b expected 10", grant); n_err++; end
      tick();
      awvalid_in = 1'b0;
      send_w(beat(40), 1'b1, ok);
      wait_out(ok);
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (!ok || {out_valid, out_addr, out_length, out_is_memwrite, out_tag} !== {1'b1, 32'h3000, 10'd8, 1'b1, 4'd1}
             || out_wdata[DW-1:0] !== beat(40) || arready_out !== 1'b0) begin
            $display("FAIL arb_wr_stall%0d: got %b/%h/%0d/%b/%h expected 1/3000/8/1/1", i,
                     out_valid, out_addr, out_length, out_is_memwrite, out_tag);
            n_err++;
         end
         tick();
      end
      accept_out();
      wait_b(ok);
      n_cmp++;
      if (!ok || bid_out !== 4'd1) begin $display("FAIL arb_bresp: got bvalid=%b bid=%h expected 1/1", bvalid_out, bid_out); n_err++; end
      accept_b();
`ifdef AXI4_REQ_SPLITTER_READ_EN
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (arready_out) ok = 1'b1;
         else tick();
      end
      n_cmp++;
      if (!ok) begin $display("FAIL arb_read_grant: got timeout expected arready"); n_err++; end
      tick();
      arvalid_in = 1'b0;
      wait_out(ok);
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (!ok || {out_valid, out_addr, out_length, out_is_memwrite, out_tag} !== {1'b1, 32'h4000, 10'd8, 1'b0, 4'd2}) begin
            $display("FAIL arb_rd_stall%0d: got %b/%h/%0d/%b/%h expected 1/4000/8/0/2", i,
                     out_valid, out_addr, out_length, out_is_memwrite, out_tag);
            n_err++;
         end
         tick();
      end
      accept_out();
`else
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if ({arready_out, out_valid} !== 2'b00) begin
            $display("FAIL arb_read_ignored%0d: got arready=%b out_valid=%b expected 0/0", i, arready_out, out_valid);
            n_err++;
         end
         tick();
      end
      arvalid_in = 1'b0;
`endif
   endtask

   task automatic test_reset_mid_burst();
      bit ok, all_ok;
      int unsigned seen;
      send_aw(4'd7, 32'h5000, 8'd7, ok);
      all_ok = ok;
      send_w(beat(60), 1'b0, ok); all_ok &= ok;
      send_w(beat(61), 1'b0, ok); all_ok &= ok;
      n_cmp++;
      if (!all_ok || wready_out !== 1'b1) begin $display("FAIL rst_mid_setup: got wready=%b expected 1", wready_out); n_err++; end
      rst_n = 1'b0;
      tick();
      n_cmp++;
      if ({awready_out, arready_out, wready_out, bvalid_out, bid_out, out_addr, out_length,
           out_is_memwrite, out_tag, out_valid} !== '0 || out_wdata !== '0) begin
         $display("FAIL rst_mid_outputs: got wready=%b addr=%h tag=%h expected all 0", wready_out, out_addr, out_tag);
         n_err++;
      end
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid || bvalid_out || wready_out) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin $display("FAIL rst_mid_discard: got %0d active cycles expected 0", seen); n_err++; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_write();
      test_multi_chunk();
`ifdef AXI4_REQ_SPLITTER_READ_EN
      test_read_split();
`endif
      test_arbitration();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi4_req_splitter.md
AXI4_REQ_SPLITTER -- requirements
Module: axi4_req_splitter

Interface
REQ-001 ID_WIDTH, 4, AXI ID width.
REQ-002 ADDR_WIDTH, 32, AXI/request address width.
REQ-003 DATA_WIDTH, 256, beat width in bits; power of two, >=32.
REQ-004 CHUNK_MAX_BEATS, 4, max beats per emitted request.
REQ-005 BDF, 16'h0100, value driven on out_bdf.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 awvalid_in  input  1  AW valid.
REQ-009 awready_out  output  1  AW ready.
REQ-010 awid_in  input  ID_WIDTH  write ID.
REQ-011 awaddr_in  input  ADDR_WIDTH  write start address, beat-aligned.
REQ-012 awlen_in  input  8  beats-1, INCR, full-width beats only.
REQ-013 wvalid_in  input  1  W valid.
REQ-014 wready_out  output  1  W ready.
REQ-015 wdata_in  input  DATA_WIDTH  write beat.
REQ-016 wlast_in  input  1  last beat of burst.
REQ-017 bvalid_out  output  1  write response valid; response always OKAY.
REQ-018 bready_in  input  1  write response ready.
REQ-019 bid_out  output  ID_WIDTH  write response ID.
REQ-020 arvalid_in  input  1  AR valid.
REQ-021 arready_out  output  1  AR ready.
REQ-022 arid_in  input  ID_WIDTH  read ID.
REQ-023 araddr_in  input  ADDR_WIDTH  read start address, beat-aligned.
REQ-024 arlen_in  input  8  beats-1, INCR.
REQ-025 out_addr  output  ADDR_WIDTH  chunk start address.
REQ-026 out_length  output  10  chunk length in DW = beats*DATA_WIDTH/32.
REQ-027 out_bdf  output  16  constant BDF.
REQ-028 out_is_memwrite  output  1  1 = write chunk, 0 = read chunk.
REQ-029 out_tag  output  ID_WIDTH  AXI ID of originating burst.
REQ-030 out_wdata  output  DATA_WIDTH*CHUNK_MAX_BEATS  beat k at bits [k*DATA_WIDTH +: DATA_WIDTH]; unused lanes 0.
REQ-031 out_valid  output  1  request valid.
REQ-032 out_ready  input  1  request ready.

Function
REQ-033 FSM states SHALL be IDLE, WR_COLLECT, WR_ISSUE, WR_RESP, RD_ISSUE.
- One burst at a time.
- Fair arbitration: in IDLE with awvalid_in and arvalid_in both high, grant alternates. After reset the first grant goes to write.
REQ-034 In IDLE, awready_out/arready_out SHALL be 1 only for the granted channel, for exactly one cycle.
- On AW handshake: latch ID, address and remaining = awlen+1; go to WR_COLLECT.
- On AR handshake: latch the same fields; go to RD_ISSUE.
REQ-035 Chunk size SHALL be min(remaining, CHUNK_MAX_BEATS, beats left before the next 4KB address boundary).
REQ-036 In WR_COLLECT:
- wready_out=1.
- Each W handshake stores the beat at the next lane.
- The chunk closes on its computed size or on wlast_in, whichever comes first; then go to WR_ISSUE with wready_out=0.
REQ-037 In WR_ISSUE and RD_ISSUE, out_valid SHALL be 1 with stable outputs until out_ready.
- After the handshake: out_addr += beats*DATA_WIDTH/8; remaining -= beats.
- If remaining>0 (and wlast not yet seen), go to the next chunk.
- Otherwise go to WR_RESP (write) or IDLE (read).
REQ-038 Early wlast_in SHALL end the burst after the current chunk. When remaining reaches 0 without wlast_in, the last beat SHALL still be treated as final.
REQ-039 In WR_RESP, bvalid_out=1 and bid_out=latched ID until bready_in; then IDLE. out_valid SHALL be 0 in this state.
REQ-040 For read chunks, out_is_memwrite=0 and out_wdata=0.
REQ-041 out_valid SHALL never rise in the same cycle as an AXI address handshake (minimum 1-cycle latency).

Reset
REQ-042 While rst_n=0, all outputs except out_bdf SHALL be 0; FSM=IDLE; arbitration pointer = write. Reset mid-burst SHALL discard the burst with no response.

Configuration
REQ-043 With macro AXI4_REQ_SPLITTER_READ_EN defined, AR handling per REQ-034..037 SHALL be compiled in.
- Undefined: arready_out is tied 0, RD_ISSUE is absent, and AR inputs are ignored.

Verification
REQ-044 Write awaddr=0x1000, awlen=3, 4 beats D0..D3 -> one request: out_addr 0x1000, out_length 32, is_memwrite 1, lanes D0..D3; then bvalid with bid=awid.
REQ-045 Write awlen=9 at 0x2000, CHUNK_MAX_BEATS=4 -> chunks 0x2000/32DW, 0x2080/32DW, 0x2100/16DW (lanes 2-3 zero); one B.
REQ-046 Read araddr=0x0FC0, arlen=3 -> chunks 0x0FC0/16DW and 0x1000/16DW (4KB split); is_memwrite 0; out_tag=arid.
REQ-047 AW and AR valid together after reset, out_ready held 0 for 5 cycles -> write served first, outputs stable while stalled, read served next.
REQ-048 rst_n pulsed low during WR_COLLECT of awlen=7 burst -> all outputs 0 next edge, no out_valid and no bvalid for that burst.
